msdf_ca_sequencer: RTL and testbench
====================================

Name: msdf_ca_sequencer

Overview:
- Control block for the online-delay CA register/RAM generator.
- Sequences `enable`, `refresh` and `accum` so that num_ops independent MSDF operations share one CA RAM set, interleaved address by address, one digit per operation per round.
- Gates the digit stream with a valid/ready handshake, and produces read-side valid/tag pipelines aligned to the RAM read ports and to the 1-cycle delayed read ports.
- Sits between the top-level MSDF scheduler (start/done) and the CA generator instance.

Parameters:
- ADDR_WIDTH, 8, width of accum/operation index; max 2^ADDR_WIDTH-1 operations.
- DIGITS, 64, digits per operation; must match the generator's shift-count wrap (64).
- DIG_W, 7, width of digit index; must satisfy 2^DIG_W > DIGITS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without done.
- num_ops  in  ADDR_WIDTH  operations in the job; latched on accepted start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job completion.
- in_valid  in  1  upstream digit pair (x_in/y_in) valid this cycle.
- in_ready  out  1  sequencer accepts a digit this cycle.
- ca_enable  out  1  to generator `enable`.
- ca_refresh  out  1  to generator `refresh`.
- ca_accum  out  ADDR_WIDTH  to generator `accum`.
- digit_idx  out  DIG_W  digit index of the current issue.
- rd_valid  out  1  generator RAM read ports (y_*_rd) carry a valid word.
- rd_addr  out  ADDR_WIDTH  operation index of that word.
- dly_valid  out  1  generator delayed ports (x_*_delay) carry a valid word.
- dly_addr  out  ADDR_WIDTH  operation index of that word.
- dly_last  out  1  dly word belongs to the final digit (DIGITS-1).
- stall_cycles  out  32  performance counter; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, all counters 0, latched num_ops=0.
  - Every output 0: busy, done, in_ready, ca_enable, ca_refresh, ca_accum, digit_idx, rd_*, dly_*, stall_cycles.
- States:
  - IDLE: start=1 and num_ops!=0 -> latch num_ops into nops, clear op_cnt and dig_cnt -> RUN. start=1 and num_ops==0 -> DONE (no issue cycles). Otherwise stay in IDLE.
  - RUN:
    - in_ready=1.
    - ca_enable=in_valid (combinational).
    - ca_accum=op_cnt, digit_idx=dig_cnt.
    - ca_refresh=in_valid & (dig_cnt==0).
    - Counters advance only on in_valid=1: op_cnt increments and wraps to 0 at nops-1; on wrap, dig_cnt increments.
    - Issue with op_cnt==nops-1 and dig_cnt==DIGITS-1 -> DRAIN.
    - in_valid=0: counters hold and outputs hold, except ca_enable=0.
  - DRAIN: exactly 2 cycles, ca_enable=0, in_ready=0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE. busy=0 in DONE.
- Read-side pipelines (not gated by stalls):
  - rd_valid/rd_addr = ca_enable/ca_accum registered once.
  - dly_valid/dly_addr/dly_last = the rd_* values registered again.
  - dly_last marks dig_cnt==DIGITS-1 at issue.
  - DRAIN length guarantees the last dly_valid occurs before done.
- Total issue count per job is nops*DIGITS.
  - With no stalls: start-to-done = nops*DIGITS + 4 cycles (1 in IDLE, issues, 2 DRAIN, then done).
- Boundaries:
  - start while busy: ignored.
  - abort: RUN/DRAIN -> IDLE next cycle. Counters clear. Pipelines flush to 0 next cycle. No done.
  - abort and start in the same IDLE cycle: abort wins.
  - nops=1: ca_refresh high on the first issue only; op_cnt stays at 0.
  - num_ops changing during a job: no effect.
  - Reset mid-job: immediate IDLE, no done.

Optional Feature:
- Macro: CA_SEQ_PERF_EN.
- Defined: stall_cycles counts RUN cycles with in_valid=0. Cleared on an accepted start. Saturates at 2^32-1. Holds its value after done.
- Undefined: stall_cycles tied to 0; no counter logic.

Test Plan:
- num_ops=3, in_valid always 1 -> 192 ca_enable cycles.
  - ca_accum sequence 0,1,2,0,1,2…; ca_refresh high on the first 3 issues only.
  - done pulse 196 cycles after start; dly_last high on the final 3 dly_valid cycles.
- num_ops=2, in_valid low on issue cycles 5–9 -> counters freeze at op=1, dig=2 and ca_enable=0 for those cycles.
  - Job completes 5 cycles later than unstalled.
  - stall_cycles=5 with CA_SEQ_PERF_EN, 0 without.
- num_ops=0 start -> done pulse 2 cycles after start; no ca_enable, busy never high.
- abort at issue 40 of a num_ops=4 job -> IDLE next cycle, no done, rd_valid/dly_valid 0 within 2 cycles.
  - A new start with num_ops=1 then runs normally with refresh on its first issue.
- rst_n asserted mid-RUN, asynchronously between clock edges -> all outputs 0 immediately.
  - start pulsed during busy is ignored: no second job, a single done.
- num_ops=1 -> ca_accum constantly 0, refresh only on issue 0, 64 issues, done at cycle 68.

Source files
------------

// File: rtl/msdf_ca_sequencer.sv
// msdf_ca_sequencer: interleaves num_ops MSDF operations over one CA RAM set, one digit per op per round.
// Define CA_SEQ_PERF_EN to build the stall_cycles performance counter (tied to 0 otherwise).
module msdf_ca_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DIGITS     = 64,
    parameter int DIG_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] num_ops,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ca_enable,
    output logic                  ca_refresh,
    output logic [ADDR_WIDTH-1:0] ca_accum,
    output logic [DIG_W-1:0]      digit_idx,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  dly_valid,
    output logic [ADDR_WIDTH-1:0] dly_addr,
    output logic                  dly_last,
    output logic [31:0]           stall_cycles
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_nops, r_op_cnt, r_rd_addr, r_dly_addr;
    logic [DIG_W-1:0] r_dig_cnt;
    logic r_drain, r_rd_valid, r_rd_last, r_dly_valid, r_dly_last;
    logic w_run, w_drain, w_issue, w_op_wrap, w_dig_last, w_accept, w_kill;

    assign w_run      = r_state == RUN;
    assign w_drain    = r_state == DRAIN;
    assign w_issue    = w_run & in_valid;
    assign w_op_wrap  = r_op_cnt == r_nops - ADDR_WIDTH'(1);
    assign w_dig_last = r_dig_cnt == DIG_W'(DIGITS - 1);
    assign w_accept   = (r_state == IDLE) & start & ~abort;
    assign w_kill     = abort & (w_run | w_drain);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (num_ops == '0) ? DONE : RUN;
            RUN:     if (abort) w_next = IDLE;
                     else if (w_issue & w_op_wrap & w_dig_last) w_next = DRAIN;
            DRAIN:   if (abort) w_next = IDLE;
                     else if (r_drain) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // r_drain marks the second DRAIN cycle so the last delayed word lands before done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nops    <= '0;
            r_op_cnt  <= '0;
            r_dig_cnt <= '0;
            r_drain   <= 1'b0;
        end else begin
            r_drain <= w_drain & ~r_drain & ~abort;
            if (w_accept) begin
                r_nops    <= num_ops;
                r_op_cnt  <= '0;
                r_dig_cnt <= '0;
            end else if (w_kill) begin
                r_op_cnt  <= '0;
                r_dig_cnt <= '0;
            end else if (w_issue) begin
                r_op_cnt <= w_op_wrap ? '0 : r_op_cnt + ADDR_WIDTH'(1);
                if (w_op_wrap) r_dig_cnt <= w_dig_last ? '0 : r_dig_cnt + DIG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_kill) begin
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_last   <= 1'b0;
            r_dly_valid <= 1'b0;
            r_dly_addr  <= '0;
            r_dly_last  <= 1'b0;
        end else begin
            r_rd_valid  <= ca_enable;
            r_rd_addr   <= ca_accum;
            r_rd_last   <= w_issue & w_dig_last;
            r_dly_valid <= r_rd_valid;
            r_dly_addr  <= r_rd_addr;
            r_dly_last  <= r_rd_last;
        end
    end

    assign busy       = w_run | w_drain;
    assign done       = r_state == DONE;
    assign in_ready   = w_run;
    assign ca_enable  = w_issue;
    assign ca_refresh = w_issue & (r_dig_cnt == '0);
    assign ca_accum   = w_run ? r_op_cnt : '0;
    assign digit_idx  = w_run ? r_dig_cnt : '0;
    assign rd_valid   = r_rd_valid;
    assign rd_addr    = r_rd_addr;
    assign dly_valid  = r_dly_valid;
    assign dly_addr   = r_dly_addr;
    assign dly_last   = r_dly_last;

`ifdef CA_SEQ_PERF_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_stall <= '0;
        else if (w_accept)                       r_stall <= '0;
        else if (w_run & ~in_valid & ~&r_stall)  r_stall <= r_stall + 32'd1;
    end
    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_msdf_ca_sequencer.sv
// tb_msdf_ca_sequencer: table-driven job vectors plus abort, reset and restart corner sequences.
module tb_msdf_ca_sequencer;
    localparam int DIGITS = 64;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
    logic [7:0] num_ops = '0;
    logic busy, done, in_ready, ca_enable, ca_refresh, rd_valid, dly_valid, dly_last;
    logic [7:0] ca_accum, rd_addr, dly_addr;
    logic [6:0] digit_idx;
    logic [31:0] stall_cycles;
    int total = 0, bad = 0;

    msdf_ca_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_ops(num_ops),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .ca_enable(ca_enable), .ca_refresh(ca_refresh), .ca_accum(ca_accum),
        .digit_idx(digit_idx), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .dly_valid(dly_valid), .dly_addr(dly_addr), .dly_last(dly_last),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n, lo, len, rs;
        int e_done, e_iss, e_refr, e_last, e_busy, e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{busy, done, in_ready, ca_enable, ca_refresh, ca_accum, digit_idx,
                 rd_valid, rd_addr, dly_valid, dly_addr, dly_last, stall_cycles};
    endfunction

    // e_done counts cycles inclusively: start cycle is 1, the done cycle is e_done
    task automatic run_job(input vec_t v);
        int cyc = 0, iss = 0, refr = 0, lastc = 0, rdc = 0, dlyc = 0, busyc = 0;
        int seq = 0, dcyc = 0, idle_err = 0, mop = 0, mdig = 0, r;
        logic pv = 0, ppv = 0, pl = 0, ppl = 0, saw_last = 0;
        logic [7:0] pa = '0, ppa = '0;
        int exp_stall;
        while (dcyc == 0 && cyc < 2000) begin
            cyc++;
            r = cyc - 2;
            @(posedge clk); #1;
            start    = (cyc == 1) || (v.rs != 0 && cyc == v.rs);
            num_ops  = (cyc == 1) ? 8'(v.n) : 8'(cyc * 7);
            in_valid = !(r >= v.lo && r < v.lo + v.len);
            @(negedge clk);
            if (rd_valid !== pv || (pv && rd_addr !== pa)) seq++;
            if (dly_valid !== ppv || (ppv && dly_addr !== ppa) || dly_last !== (ppv && ppl)) seq++;
            if ((ca_enable && !in_valid) || (ca_refresh && !ca_enable)) seq++;
            if (ca_enable) begin
                iss++;
                if (ca_accum !== 8'(mop) || digit_idx !== 7'(mdig) || ca_refresh !== (mdig == 0)) seq++;
                refr += int'(ca_refresh);
                mop++;
                if (mop == v.n) begin
                    mop = 0;
                    mdig++;
                end
            end
            if (dly_valid && !dly_last && saw_last) seq++;
            if (dly_valid && dly_last) begin
                lastc++;
                saw_last = 1;
            end
            rdc += int'(rd_valid);
            dlyc += int'(dly_valid);
            busyc += int'(busy);
            if (done) dcyc = cyc;
            ppv = pv; ppa = pa; ppl = pl;
            pv = ca_enable; pa = ca_accum; pl = ca_enable && digit_idx == 7'(DIGITS - 1);
        end
`ifdef CA_SEQ_PERF_EN
        exp_stall = v.e_stall;
`else
        exp_stall = 0;
`endif
        chk("done_cycle", 64'(dcyc), 64'(v.e_done));
        chk("issues", 64'(iss), 64'(v.e_iss));
        chk("refresh_cnt", 64'(refr), 64'(v.e_refr));
        chk("dly_last_cnt", 64'(lastc), 64'(v.e_last));
        chk("rd_valid_cnt", 64'(rdc), 64'(v.e_iss));
        chk("dly_valid_cnt", 64'(dlyc), 64'(v.e_iss));
        chk("busy_cnt", 64'(busyc), 64'(v.e_busy));
        chk("sequence_err", 64'(seq), 64'(0));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 start = 0;
            @(negedge clk);
            if (busy || done || rd_valid || dly_valid) idle_err++;
        end
        chk("idle_after_done", 64'(idle_err), 64'(0));
        chk("stall_hold", 64'(stall_cycles), 64'(exp_stall));
    endtask

    initial begin
        vec_t tv[5];
        vec_t one;
        int dn;
        tv[0] = '{3, 0, 0, 0,  196, 192, 3, 3, 194, 0};
        tv[1] = '{2, 5, 5, 0,  137, 128, 2, 2, 135, 5};
        tv[2] = '{0, 0, 0, 0,  2,   0,   0, 0, 0,   0};
        tv[3] = '{1, 0, 0, 10, 68,  64,  1, 1, 66,  0};
        tv[4] = '{5, 0, 3, 0,  327, 320, 5, 5, 325, 3};
        one   = '{1, 0, 0, 0,  68,  64,  1, 1, 66,  0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 64'(0));
        rst_n = 1;

        for (int i = 0; i < 5; i++) run_job(tv[i]);

        // abort on issue 40 of a 4-op job (op 0, digit 10)
        @(posedge clk); #1 start = 1; num_ops = 8'd4; in_valid = 1;
        for (int c = 2; c <= 42; c++) begin
            @(posedge clk); #1 start = 0; abort = (c == 42);
        end
        @(negedge clk);
        chk("abort_issue_op", 64'(ca_accum), 64'(0));
        chk("abort_issue_dig", 64'(digit_idx), 64'(10));
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_flush", 64'({busy, in_ready, ca_enable, rd_valid, dly_valid}), 64'(0));
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            dn += int'(done | busy | dly_valid);
        end
        chk("abort_no_done", 64'(dn), 64'(0));

        @(posedge clk); #1 start = 1; abort = 1; num_ops = 8'd2;
        @(posedge clk); #1 start = 0; abort = 0;
        @(negedge clk);
        chk("abort_beats_start", 64'({busy, done, in_ready}), 64'(0));

        run_job(one);

        // asynchronous reset between edges in the middle of a job
        @(posedge clk); #1 start = 1; num_ops = 8'd2; in_valid = 1;
        @(posedge clk); #1 start = 0;
        repeat (20) @(posedge clk);
        #3;
        chk("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 0;
        #1;
        chk("async_reset_outs", 64'(any_out()), 64'(0));
        @(negedge clk);
        rst_n = 1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(done | busy);
        end
        chk("reset_no_done", 64'(dn), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
